pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Program-counter and fetch-control stage directly upstream of the byte-addressed, big-endian instruction ROM.
- Holds the architectural PC and computes the next PC from control inputs (sequential, branch, jump, register jump).
- Drives the ROM's address and active-low read strobe.
- Sequences boot, run, halt and fault states for the single-cycle CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_BYTES, 100, size of the instruction ROM in bytes; used by the bound check.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- pc_write  in  1  1 = advance PC this cycle; 0 = stall and hold the PC.
- pc_src  in  2  next-PC select: 00 SEQ, 01 BRANCH, 10 JUMP, 11 JR.
- imm_ext  in  32  sign-extended branch offset, in words.
- jump_target  in  26  J-type target field.
- reg_target  in  32  register value used for JR.
- halt_in  in  1  halt instruction decoded this cycle.
- pc_out  out  32  current PC.
- pc_plus4  out  32  pc_out + 4, for link and branch datapaths.
- rom_addr  out  32  ROM address; always equals pc_out.
- rom_nrd  out  1  ROM read strobe, active low.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- instr_count  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset (async, nrst=0): pc=RESET_PC, state=BOOT, rom_nrd=1, halted=0, fault=0, instr_count=0. Reset is honoured in any state, including mid-halt or mid-fault.
- States:
  - BOOT: one cycle with rom_nrd=1 so the ROM output settles from high-Z. Goes unconditionally to RUN; PC is not updated.
  - RUN: rom_nrd=0.
  - HALT, FAULT: rom_nrd=1. Both are terminal; only reset exits them.
- Next-PC calculation (combinational, modulo 2^32, wrap-around permitted):
  - SEQ: pc+4.
  - BRANCH: pc+4+(imm_ext<<2).
  - JUMP: {pc_plus4[31:28], jump_target, 2'b00}.
  - JR: reg_target.
- RUN, rising edge, in priority order:
  1. halt_in=1: state→HALT, PC held, halted=1 from the next cycle. Halt wins over pc_write and over any fault.
  2. pc_write=0: stall; PC, state and count are held; rom_nrd stays 0.
  3. next_pc[1:0]≠0: state→FAULT, PC held at the offending instruction, fault=1.
  4. Otherwise: pc←next_pc, instr_count←instr_count+1, saturating at all-ones.
- Latency: the new PC is visible on pc_out/rom_addr one cycle after the edge, and ROM data is valid combinationally within that cycle.
- halt_in and pc_src are ignored outside RUN.
- pc_plus4 is always combinational from pc.

Optional Feature:
- Macro FETCH_BOUND_CHECK_EN.
- Defined: in RUN, a next_pc with next_pc+3 ≥ ROM_BYTES (unsigned) also sends the block to FAULT, with the same priority as misalignment. In FAULT, rom_addr is forced to RESET_PC so the ROM is never indexed out of range.
- Undefined: no range check; an out-of-range PC is passed through unchanged.

Decomposition:
- Shared package cpu_fetch_pkg holds:
  - pc_src encodings PC_SRC_SEQ/BRANCH/JUMP/JR.
  - state encodings ST_BOOT/ST_RUN/ST_HALT/ST_FAULT (2 bits).
  - INSTR_BYTES=4.
- One natural sub-module: next_pc_calc, a purely combinational mux and adders producing next_pc and the misalign flag.

Test Plan:
- Reset then 3 cycles with pc_write=1, SEQ → cycle 0 BOOT rom_nrd=1, pc=0; then pc=0,4,8 with rom_nrd=0; instr_count=2.
- pc=0x10, BRANCH, imm_ext=0xFFFF_FFFE → pc=0x0C next cycle; JUMP with jump_target=0x000_0008 from pc=0x0C → pc=0x20.
- pc_write=0 for 3 cycles at pc=0x08 → pc and instr_count unchanged, rom_nrd=0; release → pc=0x0C.
- JR with reg_target=0x0000_0006 → fault=1, pc held, rom_nrd=1; asserting halt_in alongside instead → halted=1, fault=0.
- halt_in=1 at pc=0x14, then nrst pulsed low mid-halt asynchronously → immediate pc=0, state=BOOT, halted=0, count=0.
- With FETCH_BOUND_CHECK_EN and ROM_BYTES=100, SEQ from pc=0x60 → FAULT (0x64+3 ≥ 100), rom_addr=0; without the macro → pc=0x64, no fault.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage: next-PC source select codes,
// fetch FSM state codes and the instruction size in bytes.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_JR     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/pc_fetch_if.sv
// ROM fetch bus between the PC stage and the instruction ROM.
//   rom_addr : byte address of the instruction being fetched
//   rom_nrd  : read strobe, active low
// master = fetch stage (drives), slave = ROM (receives).
interface pc_fetch_if;
    logic [31:0] rom_addr;
    logic        rom_nrd;

    modport master (output rom_addr, output rom_nrd);
    modport slave  (input  rom_addr, input  rom_nrd);
endinterface

// File: rtl/pc_fetch_next_pc_calc.sv
// Purely combinational next-PC selector.
//   pc, pc_src, imm_ext, jump_target, reg_target : inputs
//   pc_plus4 : pc + 4
//   next_pc  : selected next PC (modulo 2^32)
//   misalign : next_pc is not word aligned
module next_pc_calc
    import cpu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jump_target,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misalign
);

    assign pc_plus4 = pc + INSTR_BYTES;

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src_e'(pc_src))
            PC_SRC_SEQ:    next_pc = pc_plus4;
            // Branch offset is in words; the top two bits fall off the shift.
            PC_SRC_BRANCH: next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
            PC_SRC_JUMP:   next_pc = {pc_plus4[31:28], jump_target, 2'b00};
            PC_SRC_JR:     next_pc = reg_target;
            default:       next_pc = pc_plus4;
        endcase
    end

    assign misalign = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch control for the single-cycle CPU.
// Holds the PC, picks the next PC, drives the ROM bus and sequences
// BOOT -> RUN -> {HALT | FAULT}. HALT and FAULT are left only by reset.
// Ports:
//   clk, nrst       : clock, asynchronous active-low reset
//   pc_write        : 1 = advance, 0 = stall
//   pc_src          : next-PC select (SEQ/BRANCH/JUMP/JR)
//   imm_ext         : branch offset in words
//   jump_target     : J-type target field
//   reg_target      : JR target
//   halt_in         : halt decoded this cycle
//   rom             : ROM bus (rom_addr, rom_nrd)
//   pc_out, pc_plus4, halted, fault, instr_count : status outputs
// Build option: FETCH_BOUND_CHECK_EN adds a ROM range check that faults on
// out-of-range targets and parks rom_addr at RESET_PC while in FAULT.
module pc_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 100,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             pc_write,
    input  logic [1:0]       pc_src,
    input  logic [31:0]      imm_ext,
    input  logic [25:0]      jump_target,
    input  logic [31:0]      reg_target,
    input  logic             halt_in,
    pc_fetch_if.master       rom,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    fetch_state_e     st_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rom_nrd_q, halted_q, fault_q;
    logic [31:0]      next_pc;
    logic             misalign, out_of_range, bad_target;

    next_pc_calc u_npc (
        .pc          (pc_q),
        .pc_src      (pc_src),
        .imm_ext     (imm_ext),
        .jump_target (jump_target),
        .reg_target  (reg_target),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc),
        .misalign    (misalign)
    );

    // Last byte of the fetched word must lie inside the ROM; 33 bits so a
    // target near 2^32 cannot wrap back into range.
    assign out_of_range = ({1'b0, next_pc} + 33'd3) >= {1'b0, ROM_BYTES};
    assign bad_target   = misalign | (BOUND_EN & out_of_range);

    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st_q      <= ST_BOOT;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            rom_nrd_q <= 1'b1;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (st_q)
                ST_BOOT: begin
                    st_q      <= ST_RUN;
                    rom_nrd_q <= 1'b0;
                end
                ST_RUN: begin
                    if (halt_in) begin
                        st_q      <= ST_HALT;
                        halted_q  <= 1'b1;
                        rom_nrd_q <= 1'b1;
                    end else if (pc_write) begin
                        if (bad_target) begin
                            st_q      <= ST_FAULT;
                            fault_q   <= 1'b1;
                            rom_nrd_q <= 1'b1;
                        end else begin
                            pc_q  <= next_pc;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: ;  // HALT / FAULT hold until reset
            endcase
        end
    end

    assign pc_out       = pc_q;
    assign rom.rom_addr = (BOUND_EN && st_q == ST_FAULT) ? RESET_PC : pc_q;
    assign rom.rom_nrd  = rom_nrd_q;
    assign halted       = halted_q;
    assign fault        = fault_q;
    assign instr_count  = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0;
    localparam int unsigned ROMB = 100;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        pc_write = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] imm_ext = '0;
    logic [25:0] jump_target = '0;
    logic [31:0] reg_target = '0;
    logic        halt_in = 1'b0;
    logic [31:0] pc_out, pc_plus4, instr_count;
    logic        halted, fault;

    pc_fetch_if rom_if ();

    pc_fetch #(.RESET_PC(RST_PC), .ROM_BYTES(ROMB), .CNT_W(32)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .imm_ext     (imm_ext),
        .jump_target (jump_target),
        .reg_target  (reg_target),
        .halt_in     (halt_in),
        .rom         (rom_if),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 boot, 1 run, 2 halt, 3 fault.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    function automatic logic [31:0] target(input logic [31:0] pc, input logic [1:0] src,
                                           input logic [31:0] imm, input logic [25:0] jt,
                                           input logic [31:0] rt);
        logic [31:0] seq;
        seq = pc + 32'd4;
        case (src)
            2'd0:    return seq;
            2'd1:    return seq + imm * 32'd4;
            2'd2:    return (seq & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
            default: return rt;
        endcase
    endfunction

    function automatic bit illegal(input logic [31:0] a);
        longint unsigned last;
        last = longint'(a) + 3;
        return (a % 4 != 0) || (BOUND && last >= ROMB);
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_mode <= 0;
            m_pc   <= RST_PC;
            m_cnt  <= 0;
        end else if (m_mode == 0) begin
            m_mode <= 1;
        end else if (m_mode == 1) begin
            if (halt_in) m_mode <= 2;
            else if (pc_write) begin
                if (illegal(target(m_pc, pc_src, imm_ext, jump_target, reg_target)))
                    m_mode <= 3;
                else begin
                    m_pc  <= target(m_pc, pc_src, imm_ext, jump_target, reg_target);
                    m_cnt <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (nrst) begin
            chk("pc_out",      pc_out,          m_pc);
            chk("pc_plus4",    pc_plus4,        m_pc + 32'd4);
            chk("rom_addr",    rom_if.rom_addr, (BOUND && m_mode == 3) ? RST_PC : m_pc);
            chk("rom_nrd",     {31'd0, rom_if.rom_nrd}, {31'd0, m_mode != 1});
            chk("halted",      {31'd0, halted}, {31'd0, m_mode == 2});
            chk("fault",       {31'd0, fault},  {31'd0, m_mode == 3});
            chk("instr_count", instr_count,     m_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] s, input logic h);
        pc_write = w;
        pc_src   = s;
        halt_in  = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 nrst = 1'b0;
        @(negedge clk);
        #1 nrst = 1'b1;
    endtask

    initial begin
        #1 nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 nrst = 1'b1;
        drive(1'b1, 2'd0, 1'b0);
        // Cycle 0 is BOOT.
        chk("lit_boot_pc",  pc_out, 32'h0);
        chk("lit_boot_nrd", {31'd0, rom_if.rom_nrd}, 32'd1);
        chk("lit_boot_cnt", instr_count, 32'd0);
        step();
        chk("lit_run_pc",  pc_out, 32'h0);
        chk("lit_run_nrd", {31'd0, rom_if.rom_nrd}, 32'd0);
        step();
        chk("lit_pc4", pc_out, 32'h4);
        step();
        chk("lit_pc8",  pc_out, 32'h8);
        chk("lit_cnt2", instr_count, 32'd2);

        // Stall three cycles.
        drive(1'b0, 2'd0, 1'b0);
        repeat (3) step();
        chk("lit_stall_pc",  pc_out, 32'h8);
        chk("lit_stall_cnt", instr_count, 32'd2);
        chk("lit_stall_nrd", {31'd0, rom_if.rom_nrd}, 32'd0);
        drive(1'b1, 2'd0, 1'b0);
        step();
        chk("lit_release", pc_out, 32'hC);
        step();
        chk("lit_pc10", pc_out, 32'h10);

        // Backward branch by two words, then J-type jump.
        imm_ext = 32'hFFFF_FFFE;
        drive(1'b1, 2'd1, 1'b0);
        step();
        chk("lit_branch", pc_out, 32'hC);
        jump_target = 26'h000_0008;
        drive(1'b1, 2'd2, 1'b0);
        step();
        chk("lit_jump",     pc_out, 32'h20);
        chk("lit_jump_cnt", instr_count, 32'd6);

        // Misaligned JR faults; PC held; later inputs ignored.
        reg_target = 32'h6;
        drive(1'b1, 2'd3, 1'b0);
        step();
        chk("lit_fault",     {31'd0, fault}, 32'd1);
        chk("lit_fault_pc",  pc_out, 32'h20);
        chk("lit_fault_nrd", {31'd0, rom_if.rom_nrd}, 32'd1);
        drive(1'b1, 2'd0, 1'b1);
        repeat (2) step();
        chk("lit_fault_stuck", {31'd0, fault}, 32'd1);
        chk("lit_fault_nohalt", {31'd0, halted}, 32'd0);

        // Halt beats the misaligned target.
        drive(1'b1, 2'd0, 1'b0);
        do_reset();
        step();
        reg_target = 32'h14;
        drive(1'b1, 2'd3, 1'b0);
        step();
        chk("lit_jr", pc_out, 32'h14);
        reg_target = 32'h6;
        drive(1'b1, 2'd3, 1'b1);
        step();
        chk("lit_halt",    {31'd0, halted}, 32'd1);
        chk("lit_halt_nf", {31'd0, fault}, 32'd0);
        chk("lit_halt_pc", pc_out, 32'h14);
        drive(1'b1, 2'd0, 1'b0);
        step();

        // Asynchronous reset mid-halt takes effect without a clock edge.
        #2 nrst = 1'b0;
        #1;
        chk("lit_arst_pc",  pc_out, 32'h0);
        chk("lit_arst_hlt", {31'd0, halted}, 32'd0);
        chk("lit_arst_cnt", instr_count, 32'd0);
        chk("lit_arst_nrd", {31'd0, rom_if.rom_nrd}, 32'd1);
        @(negedge clk);
        #1 nrst = 1'b1;
        step();

        // Range check near the top of the ROM.
        reg_target = 32'h60;
        drive(1'b1, 2'd3, 1'b0);
        step();
        chk("lit_pc60", pc_out, 32'h60);
        drive(1'b1, 2'd0, 1'b0);
        step();
`ifdef FETCH_BOUND_CHECK_EN
        chk("lit_oob_fault", {31'd0, fault}, 32'd1);
        chk("lit_oob_addr",  rom_if.rom_addr, 32'h0);
        chk("lit_oob_pc",    pc_out, 32'h60);
`else
        chk("lit_oob_pc",    pc_out, 32'h64);
        chk("lit_oob_nf",    {31'd0, fault}, 32'd0);
        chk("lit_oob_addr",  rom_if.rom_addr, 32'h64);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
